// File: rtl/err_demod_pkg.sv
// Shared types and width helpers for the FOG square-wave demodulator.
package err_demod_pkg;

   localparam int unsigned AVG_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } demod_state_e;

   function automatic int unsigned acc_width(input int unsigned adc_w, input int unsigned max_log2);
      return adc_w + max_log2;
   endfunction

   // Limit the requested averaging depth to what the accumulator can hold.
   function automatic logic [AVG_SEL_W-1:0] avg_clamp(input logic [AVG_SEL_W-1:0] sel,
                                                      input int unsigned max_log2);
      return (32'(sel) > max_log2) ? AVG_SEL_W'(max_log2) : sel;
   endfunction

endpackage

// File: rtl/err_half_accum.sv
// One modulation half: settling-wait countdown, then accumulation of 2^avg_eff
// sign-extended ADC samples. sum is stable from the cycle done pulses.
module err_half_accum
   import err_demod_pkg::*;
#(
   parameter int unsigned ADC_W        = 14,
   parameter int unsigned MAX_AVG_LOG2 = 8,
   parameter int unsigned WAIT_W       = 16
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      start,
   input  logic                                      wait_en,
   input  logic                                      acc_en,
   input  logic [WAIT_W-1:0]                         wait_cnt,
   input  logic [AVG_SEL_W-1:0]                      avg_eff,
   input  logic [ADC_W-1:0]                          adc_data,
   output logic [acc_width(ADC_W, MAX_AVG_LOG2)-1:0] sum,
   output logic                                      done,
   output logic                                      busy,
   output logic                                      wait_last_c,
   output logic                                      acc_last_c
);

   localparam int unsigned ACC_W = acc_width(ADC_W, MAX_AVG_LOG2);
   localparam int unsigned SMP_W = MAX_AVG_LOG2;

   logic [WAIT_W-1:0] wait_q;
   logic [SMP_W-1:0]  smp_q;
   logic [ACC_W-1:0]  adc_ext;

   assign adc_ext     = {{MAX_AVG_LOG2{adc_data[ADC_W-1]}}, adc_data};
   assign wait_last_c = (wait_q == WAIT_W'(1));
   assign acc_last_c  = (smp_q == '0);

   // A new start always wins, discarding any partial accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
         smp_q  <= '0;
         sum    <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            wait_q <= wait_cnt;
            smp_q  <= SMP_W'((32'd1 << avg_eff) - 32'd1);
            sum    <= '0;
            busy   <= 1'b1;
         end else if (wait_en) begin
            wait_q <= wait_q - WAIT_W'(1);
         end else if (acc_en) begin
            sum   <= sum + adc_ext;
            smp_q <= smp_q - SMP_W'(1);
            if (acc_last_c) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/err_signal_gen_v6.sv
// FOG closed-loop square-wave demodulator: err = polarity * mean(high - low) + offset.
// Define ERR_SAT_EN for a saturating output with a sticky o_sat flag.
module err_signal_gen_v6
   import err_demod_pkg::*;
#(
   parameter int unsigned ADC_W        = 14,
   parameter int unsigned ERR_W        = 32,
   parameter int unsigned MAX_AVG_LOG2 = 8,
   parameter int unsigned WAIT_W       = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_status,
   input  logic                 i_trig,
   input  logic                 i_polarity,
   input  logic [WAIT_W-1:0]    i_wait_cnt,
   input  logic [AVG_SEL_W-1:0] i_avg_sel,
   input  logic [ERR_W-1:0]     i_err_offset,
   input  logic [ADC_W-1:0]     i_adc_data,
   output logic [ERR_W-1:0]     o_err,
   output logic                 o_err_vld,
   output logic                 o_ramp_sync,
   output logic                 o_step_sync,
   output logic                 o_ovr,
   output logic                 o_sat
);

   localparam int unsigned ACC_W = acc_width(ADC_W, MAX_AVG_LOG2);
   localparam int unsigned DIF_W = ACC_W + 1;
`ifdef ERR_SAT_EN
   localparam int unsigned SUM_W = ERR_W + 1;
`else
   localparam int unsigned SUM_W = ERR_W;
`endif

   demod_state_e            state_q, state_nxt;
   logic                    start_c, ovr_c;
   logic                    wait_last_c, acc_last_c, half_done, half_busy;
   logic [ACC_W-1:0]        half_sum, sum_h_q, sum_l_q;
   logic                    half_q, hv_q, cmp_q;
   logic [AVG_SEL_W-1:0]    avg_q, cmp_avg_q, avg_sel_c;
   logic signed [DIF_W-1:0] diff_c, shift_c, dem_c;
   logic signed [SUM_W-1:0] total_c;
   logic [ERR_W-1:0]        err_c;

   assign avg_sel_c = avg_clamp(i_avg_sel, MAX_AVG_LOG2);

   err_half_accum #(
      .ADC_W        (ADC_W),
      .MAX_AVG_LOG2 (MAX_AVG_LOG2),
      .WAIT_W       (WAIT_W)
   ) u_half (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .start       (start_c),
      .wait_en     (state_q == WAIT),
      .acc_en      (state_q == ACC),
      .wait_cnt    (i_wait_cnt),
      .avg_eff     (avg_sel_c),
      .adc_data    (i_adc_data),
      .sum         (half_sum),
      .done        (half_done),
      .busy        (half_busy),
      .wait_last_c (wait_last_c),
      .acc_last_c  (acc_last_c)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_nxt;
   end

   // Any trigger restarts a half; one landing while the half is busy is an overrun.
   always_comb begin
      state_nxt = state_q;
      start_c   = 1'b0;
      ovr_c     = i_trig && half_busy;
      case (state_q)
         IDLE, DONE: start_c = i_trig;
         WAIT: begin
            start_c = i_trig;
            if (wait_last_c) state_nxt = ACC;
         end
         ACC: begin
            start_c = i_trig;
            if (acc_last_c) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
      if (start_c) state_nxt = (i_wait_cnt == '0) ? ACC : WAIT;
   end

   // Difference is widened one bit so it cannot overflow before the mean shift.
   always_comb begin
      diff_c  = $signed({sum_h_q[ACC_W-1], sum_h_q}) - $signed({sum_l_q[ACC_W-1], sum_l_q});
      shift_c = diff_c >>> cmp_avg_q;
      dem_c   = i_polarity ? -shift_c : shift_c;
      total_c = SUM_W'(dem_c) + SUM_W'($signed(i_err_offset));
      err_c   = total_c[ERR_W-1:0];
`ifdef ERR_SAT_EN
      if (total_c[ERR_W] != total_c[ERR_W-1])
         err_c = total_c[ERR_W] ? {1'b1, {(ERR_W-1){1'b0}}} : {1'b0, {(ERR_W-1){1'b1}}};
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err       <= '0;
         o_err_vld   <= 1'b0;
         o_ramp_sync <= 1'b0;
         o_step_sync <= 1'b0;
         o_ovr       <= 1'b0;
         half_q      <= 1'b0;
         avg_q       <= '0;
         cmp_avg_q   <= '0;
         sum_h_q     <= '0;
         sum_l_q     <= '0;
         hv_q        <= 1'b0;
         cmp_q       <= 1'b0;
      end else begin
         o_err_vld   <= cmp_q;
         o_ramp_sync <= o_err_vld;
         o_step_sync <= i_trig;
         o_ovr       <= ovr_c;
         cmp_q       <= half_done && !half_q && hv_q;
         if (start_c) begin
            half_q <= i_status;
            avg_q  <= avg_sel_c;
         end
         if (half_done) begin
            if (half_q) begin
               sum_h_q <= half_sum;
               hv_q    <= 1'b1;
            end else if (hv_q) begin
               sum_l_q   <= half_sum;
               cmp_avg_q <= avg_q;
            end
         end
         if (cmp_q) begin
            o_err <= err_c;
            hv_q  <= 1'b0;
         end
         if (ovr_c) hv_q <= 1'b0;
      end
   end

`ifdef ERR_SAT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                                           o_sat <= 1'b0;
      else if (cmp_q && (total_c[ERR_W] != total_c[ERR_W-1])) o_sat <= 1'b1;
   end
`else
   assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_err_signal_gen_v6.sv
// Directed self-checking bench for err_signal_gen_v6 (honours ERR_SAT_EN).
module tb_err_signal_gen_v6;

   localparam int unsigned ADC_W        = 14;
   localparam int unsigned ERR_W        = 32;
   localparam int unsigned MAX_AVG_LOG2 = 8;
   localparam int unsigned WAIT_W       = 16;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_status = 1'b0;
   logic              i_trig = 1'b0;
   logic              i_polarity = 1'b0;
   logic [WAIT_W-1:0] i_wait_cnt = '0;
   logic [3:0]        i_avg_sel = '0;
   logic [ERR_W-1:0]  i_err_offset = '0;
   logic [ADC_W-1:0]  i_adc_data = '0;
   logic [ERR_W-1:0]  o_err;
   logic              o_err_vld, o_ramp_sync, o_step_sync, o_ovr, o_sat;

   int n_vec = 0;
   int n_err = 0;

   err_signal_gen_v6 #(
      .ADC_W(ADC_W), .ERR_W(ERR_W), .MAX_AVG_LOG2(MAX_AVG_LOG2), .WAIT_W(WAIT_W)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_status(i_status), .i_trig(i_trig),
      .i_polarity(i_polarity), .i_wait_cnt(i_wait_cnt), .i_avg_sel(i_avg_sel),
      .i_err_offset(i_err_offset), .i_adc_data(i_adc_data), .o_err(o_err),
      .o_err_vld(o_err_vld), .o_ramp_sync(o_ramp_sync), .o_step_sync(o_step_sync),
      .o_ovr(o_ovr), .o_sat(o_sat)
   );

   always #5 i_clk = ~i_clk;

   task automatic set_cfg(input int w, input int avg, input logic pol, input logic [ERR_W-1:0] off);
      i_wait_cnt   = WAIT_W'(w);
      i_avg_sel    = 4'(avg);
      i_polarity   = pol;
      i_err_offset = off;
   endtask

   // Trigger is sampled on the posedge between the two negedges.
   task automatic trig_pulse(input logic status, input int adc);
      @(negedge i_clk);
      i_status   = status;
      i_adc_data = ADC_W'(adc);
      i_trig     = 1'b1;
      @(negedge i_clk);
      i_trig     = 1'b0;
   endtask

   task automatic run_half(input logic status, input int adc, input int len);
      trig_pulse(status, adc);
      repeat (len) @(negedge i_clk);
   endtask

   task automatic wait_vld(input int bound, output int lat);
      lat = -1;
      for (int k = 1; k <= bound; k++) begin
         @(negedge i_clk);
         if (o_err_vld === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic watch(input int cycles, output int nv, output int novr);
      nv = 0;
      novr = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge i_clk);
         if (o_err_vld === 1'b1) nv++;
         if (o_ovr === 1'b1) novr++;
      end
   endtask

   task automatic test_reset;
      n_vec++;
      if ({o_err, o_err_vld, o_ramp_sync, o_step_sync, o_ovr, o_sat} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got err=%h vld=%b ramp=%b step=%b ovr=%b sat=%b expected all 0",
                  o_err, o_err_vld, o_ramp_sync, o_step_sync, o_ovr, o_sat);
      end
   endtask

   task automatic test_steady;
      int lat;
      set_cfg(3, 2, 1'b0, '0);
      run_half(1'b1, 100, 12);
      trig_pulse(1'b0, -100);
      n_vec++;
      if (o_step_sync !== 1'b1) begin
         n_err++; $display("FAIL step_sync_hi: got %b expected 1", o_step_sync);
      end
      wait_vld(30, lat);
      n_vec++;
      if (lat != 9) begin
         n_err++; $display("FAIL steady_latency: got %0d expected 9", lat);
      end
      n_vec++;
      if (o_err !== ERR_W'(200)) begin
         n_err++; $display("FAIL steady_err: got %0d expected 200", $signed(o_err));
      end
      @(negedge i_clk);
      n_vec++;
      if (o_ramp_sync !== 1'b1) begin
         n_err++; $display("FAIL ramp_sync: got %b expected 1", o_ramp_sync);
      end
      n_vec++;
      if (o_err_vld !== 1'b0) begin
         n_err++; $display("FAIL vld_one_cycle: got %b expected 0", o_err_vld);
      end
   endtask

   task automatic test_polarity_clamp;
      int lat;
      set_cfg(3, 2, 1'b1, ERR_W'(50));
      run_half(1'b1, 100, 12);
      trig_pulse(1'b0, -100);
      wait_vld(30, lat);
      n_vec++;
      if (lat != 9) begin
         n_err++; $display("FAIL polarity_latency: got %0d expected 9", lat);
      end
      n_vec++;
      if (o_err !== ERR_W'(-150)) begin
         n_err++; $display("FAIL polarity_err: got %0d expected -150", $signed(o_err));
      end
      set_cfg(3, 15, 1'b0, '0);
      run_half(1'b1, 100, 270);
      trig_pulse(1'b0, -100);
      wait_vld(300, lat);
      n_vec++;
      if (lat != 261) begin
         n_err++; $display("FAIL clamp_latency: got %0d expected 261", lat);
      end
      n_vec++;
      if (o_err !== ERR_W'(200)) begin
         n_err++; $display("FAIL clamp_err: got %0d expected 200", $signed(o_err));
      end
   endtask

   task automatic test_wait_zero;
      int lat;
      set_cfg(0, 0, 1'b0, '0);
      run_half(1'b1, 7, 6);
      trig_pulse(1'b0, -5);
      wait_vld(10, lat);
      n_vec++;
      if (lat != 3) begin
         n_err++; $display("FAIL w0_latency: got %0d expected 3", lat);
      end
      n_vec++;
      if (o_err !== ERR_W'(12)) begin
         n_err++; $display("FAIL w0_err: got %0d expected 12", $signed(o_err));
      end
   endtask

   task automatic test_overrun;
      int lat, nv, novr;
      // trigger two samples into ACC (W=3, N=16)
      set_cfg(3, 4, 1'b0, '0);
      trig_pulse(1'b1, 60);
      repeat (4) @(negedge i_clk);
      trig_pulse(1'b0, -20);
      n_vec++;
      if (o_ovr !== 1'b1) begin
         n_err++; $display("FAIL ovr_pulse: got %b expected 1", o_ovr);
      end
      @(negedge i_clk);
      n_vec++;
      if (o_ovr !== 1'b0) begin
         n_err++; $display("FAIL ovr_width: got %b expected 0", o_ovr);
      end
      watch(40, nv, novr);
      n_vec++;
      if (nv != 0 || novr != 0) begin
         n_err++; $display("FAIL ovr_no_output: got vld=%0d ovr=%0d expected 0 0", nv, novr);
      end
      // trigger on the final sample edge (W=3, N=4 -> T+7)
      set_cfg(3, 2, 1'b0, '0);
      trig_pulse(1'b1, 100);
      repeat (5) @(negedge i_clk);
      trig_pulse(1'b0, -100);
      n_vec++;
      if (o_ovr !== 1'b1) begin
         n_err++; $display("FAIL ovr_last_sample: got %b expected 1", o_ovr);
      end
      watch(30, nv, novr);
      n_vec++;
      if (nv != 0) begin
         n_err++; $display("FAIL ovr_last_no_output: got %0d expected 0", nv);
      end
      set_cfg(3, 4, 1'b0, '0);
      run_half(1'b1, 60, 24);
      trig_pulse(1'b0, -20);
      wait_vld(40, lat);
      n_vec++;
      if (lat != 21) begin
         n_err++; $display("FAIL ovr_recover_latency: got %0d expected 21", lat);
      end
      n_vec++;
      if (o_err !== ERR_W'(80)) begin
         n_err++; $display("FAIL ovr_recover_err: got %0d expected 80", $signed(o_err));
      end
   endtask

   task automatic test_startup;
      int lat, nv, novr;
      @(negedge i_clk);
      i_rst_n  = 1'b0;
      i_status = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      n_vec++;
      if (o_err !== '0) begin
         n_err++; $display("FAIL startup_err_reset: got %0d expected 0", $signed(o_err));
      end
      set_cfg(3, 2, 1'b0, '0);
      trig_pulse(1'b0, -100);
      watch(20, nv, novr);
      n_vec++;
      if (nv != 0) begin
         n_err++; $display("FAIL startup_unpaired_low: got %0d expected 0", nv);
      end
      run_half(1'b1, -50, 12);
      trig_pulse(1'b0, 30);
      wait_vld(30, lat);
      n_vec++;
      if (lat != 9) begin
         n_err++; $display("FAIL startup_latency: got %0d expected 9", lat);
      end
      n_vec++;
      if (o_err !== ERR_W'(-80)) begin
         n_err++; $display("FAIL startup_err: got %0d expected -80", $signed(o_err));
      end
   endtask

   task automatic test_saturation;
      int lat;
      logic [ERR_W-1:0] exp_err;
      logic             exp_sat;
`ifdef ERR_SAT_EN
      exp_err = 32'h7FFF_FFFF;
      exp_sat = 1'b1;
`else
      exp_err = 32'h8000_005A;
      exp_sat = 1'b0;
`endif
      set_cfg(3, 2, 1'b0, 32'h7FFF_FFF6);
      run_half(1'b1, 50, 12);
      trig_pulse(1'b0, -50);
      wait_vld(30, lat);
      n_vec++;
      if (o_err !== exp_err) begin
         n_err++; $display("FAIL sat_err: got %h expected %h", o_err, exp_err);
      end
      n_vec++;
      if (o_sat !== exp_sat) begin
         n_err++; $display("FAIL sat_flag: got %b expected %b", o_sat, exp_sat);
      end
   endtask

   task automatic test_reset_mid_acc;
      int lat, nv, novr;
      set_cfg(3, 4, 1'b0, '0);
      trig_pulse(1'b1, 60);
      repeat (5) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      n_vec++;
      if ({o_err, o_err_vld, o_ramp_sync, o_step_sync, o_ovr, o_sat} !== '0) begin
         n_err++;
         $display("FAIL async_reset_outputs: got err=%h vld=%b ramp=%b step=%b ovr=%b sat=%b expected all 0",
                  o_err, o_err_vld, o_ramp_sync, o_step_sync, o_ovr, o_sat);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      watch(30, nv, novr);
      n_vec++;
      if (nv != 0 || novr != 0) begin
         n_err++; $display("FAIL post_reset_quiet: got vld=%0d ovr=%0d expected 0 0", nv, novr);
      end
      trig_pulse(1'b1, 60);
      n_vec++;
      if (o_ovr !== 1'b0) begin
         n_err++; $display("FAIL post_reset_idle: got ovr=%b expected 0", o_ovr);
      end
      repeat (24) @(negedge i_clk);
      trig_pulse(1'b0, -20);
      wait_vld(40, lat);
      n_vec++;
      if (lat != 21) begin
         n_err++; $display("FAIL post_reset_latency: got %0d expected 21", lat);
      end
      n_vec++;
      if (o_err !== ERR_W'(80)) begin
         n_err++; $display("FAIL post_reset_err: got %0d expected 80", $signed(o_err));
      end
   endtask

   initial begin
      #23 i_rst_n = 1'b1;
      @(negedge i_clk);
      test_reset();
      test_steady();
      test_polarity_clamp();
      test_wait_zero();
      test_overrun();
      test_startup();
      test_saturation();
      test_reset_mid_acc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/err_signal_gen_v6.md
Name: err_signal_gen_v6

Overview:
- Parametrised square-wave demodulator for the FOG closed loop. Sits between the ADC and the feedback/ramp logic, and is driven by the modulation generator's status and step-trigger.
- Each half-period it waits a programmable settling time, then accumulates 2^avg_sel ADC samples.
- After every high/low pair it outputs err = polarity * mean(high - low) + offset.
- New relative to v5: generic ADC/err widths, bounded averaging depth, an overrun detector, and an optional saturating output.

Parameters:
- ADC_W, 14, signed ADC sample width.
- ERR_W, 32, signed error output width; must be >= ADC_W+2.
- MAX_AVG_LOG2, 8, maximum log2 of samples averaged per half-period.
- WAIT_W, 16, width of the settling-wait counter.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_status  in  1  modulation half: 1 = high half, 0 = low half.
- i_trig  in  1  one-cycle pulse at each modulation edge.
- i_polarity  in  1  1 = negate the demodulated difference.
- i_wait_cnt  in  WAIT_W  settling cycles after the trigger.
- i_avg_sel  in  4  log2 of the sample count; clamped to MAX_AVG_LOG2.
- i_err_offset  in  ERR_W  signed offset added to the error.
- i_adc_data  in  ADC_W  signed ADC sample.
- o_err  out  ERR_W  registered signed error.
- o_err_vld  out  1  one-cycle pulse when o_err updates.
- o_ramp_sync  out  1  o_err_vld delayed by one cycle.
- o_step_sync  out  1  i_trig delayed by one cycle.
- o_ovr  out  1  one-cycle pulse when a half-period is aborted.
- o_sat  out  1  sticky saturation flag; constant 0 without ERR_SAT_EN.

Behaviour:
- Clock and reset: single clock i_clk; i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; accumulators, sums and the high-valid bit cleared.
- Widths: ACC_W = ADC_W + MAX_AVG_LOG2; N = 2^avg_eff.
- Latch on trigger: on i_trig, latch half = i_status, W = i_wait_cnt, avg_eff = min(i_avg_sel, MAX_AVG_LOG2).
- FSM, IDLE: on i_trig go to WAIT.
- FSM, WAIT: count W cycles. If W = 0, go to ACC on the next cycle.
- FSM, ACC: add sign-extended i_adc_data every cycle for N cycles. On the last sample:
  - half = 1: store sum_H and set hv.
  - half = 0: store sum_L.
  - Then go to DONE.
- FSM, DONE: if the completed half was low and hv = 1, perform the compute, clear hv, then remain in DONE. On i_trig, restart as from IDLE.
- Timing: with the trigger at cycle T, samples are taken in cycles T+1+W .. T+W+N. The low-half completion drives o_err and o_err_vld at T+W+N+2.
- Compute: d = (sum_H - sum_L) in ACC_W+1 bits, arithmetically shifted right by avg_eff. Negate if i_polarity is 1 (sampled at compute time). Sign-extend to ERR_W+1 bits and add i_err_offset. Without ERR_SAT_EN, truncate to ERR_W (wraps).
- Overrun: i_trig while in WAIT or ACC pulses o_ovr, discards the partial accumulation and clears hv, then restarts WAIT with the new latches. o_err is not updated for that pair.
- Pairing: a low half with hv = 0 (e.g. the first half after reset) produces no output.
- Stability: i_trig coincident with the last ACC sample counts as overrun, so the output never depends on partial data. Mid-operation changes of i_wait_cnt or i_avg_sel take effect only at the next i_trig.
- o_step_sync is independent of the FSM.

Optional Feature:
- ERR_SAT_EN defined: the final sum clamps to [-2^(ERR_W-1), 2^(ERR_W-1)-1], and o_sat is set on any clamp. o_sat is cleared only by reset.
- ERR_SAT_EN undefined: two's-complement wrap; o_sat tied to 0.

Decomposition:
- Package err_demod_pkg holds:
  - the state enum (IDLE, WAIT, ACC, DONE);
  - localparam/function helpers for ACC_W and the avg clamp.
- Sub-module err_half_accum holds the wait counter, sample counter and accumulator, with outputs sum, done and busy.
- Top level holds the FSM glue, sum_H/sum_L, compute, saturation and sync outputs.

Test Plan:
1. Steady modulation: ADC_W=14, W=3, avg_sel=2, ADC = +100 in high half and -100 in low, offset 0, polarity 0 -> o_err = 200. o_err_vld pulses 3+4+2 = 9 cycles after the low-half trigger. o_ramp_sync follows one cycle later.
2. Same as case 1 with polarity=1 and offset=50 -> o_err = -150; with avg_sel=15 the clamp gives N = 256 and o_err is still 200 at polarity 0.
3. Overrun: a trigger arriving 2 cycles into ACC with avg_sel=4 -> o_ovr is a 1-cycle pulse, there is no o_err_vld for that pair, and the next clean pair gives the correct value.
4. Start-up: reset released during the low half -> the first o_err_vld appears only after a full high-then-low pair.
5. ERR_SAT_EN build: offset = 2^31-10 with diff = +100 -> o_err = 2^31-1 and o_sat = 1. Non-SAT build -> wrapped negative value and o_sat = 0.
6. Reset asserted mid-ACC -> all outputs are 0 asynchronously, and the FSM returns to IDLE.
